// File: rtl/uart_sample_framer.sv
// Buffers 16-bit samples in a FIFO and emits each one as a 4-byte frame
// (sync, high byte, low byte, hi^lo checksum) over a byte-wide UART handshake.
module uart_sample_framer #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              sample_in,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    // states: IDLE pop head | SEND strobe byte | WAIT_BUSY await tx accept | WAIT_DONE await tx idle
    typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic          overflow_q;
    state_t        state_q, state_d;
    logic [15:0]   sample_q, sample_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          full, wr_en, pop;
    logic [7:0]    frame_byte;

    assign full         = (level_q == FULL_LVL);
    assign wr_en        = sample_valid & ~full;
    assign sample_ready = ~full;
    assign fifo_level   = level_q;
    assign overflow     = overflow_q;
    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    always_comb begin
        level_d = level_q;
        if (wr_en && !pop) begin
            level_d = level_q + (AW+1)'(1);
        end else if (!wr_en && pop) begin
            level_d = level_q - (AW+1)'(1);
        end
    end

    always_comb begin
        case (byte_idx_q)
            2'd0:    frame_byte = SYNC_BYTE;
            2'd1:    frame_byte = sample_q[15:8];
            2'd2:    frame_byte = sample_q[7:0];
            default: frame_byte = sample_q[15:8] ^ sample_q[7:0];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        sample_d   = sample_q;
        byte_idx_d = byte_idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop        = 1'b1;
                    sample_d   = mem_q[rd_ptr_q];
                    byte_idx_d = 2'd0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    tx_data_d  = frame_byte;
                    tx_valid_d = 1'b1;
                    state_d    = WAIT_BUSY;
                end
            end
            // tx_ready is still high right after the strobe; only a low proves acceptance
            WAIT_BUSY: begin
                if (!tx_ready) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_ready) begin
                    if (byte_idx_q == 2'd3) begin
                        state_d = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            sample_q   <= '0;
            byte_idx_q <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (sample_valid && full) begin
                overflow_q <= 1'b1;
            end
            level_q    <= level_d;
            state_q    <= state_d;
            sample_q   <= sample_d;
            byte_idx_q <= byte_idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end
endmodule

// File: tb/tb_uart_sample_framer.sv
// Bench for uart_sample_framer: a serialising UART TX model (4 clocks/bit) plus
// a line decoder; expected bytes come from a frame-level queue model.
module tb_uart_sample_framer;
    localparam int DEPTH = 16;
    localparam int CPB   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [$clog2(DEPTH):0] fifo_level;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q [$];
    logic [7:0] cap_q [$];
    logic [7:0] rx_q  [$];
    int         strobe_cnt = 0;
    int         stale_cfg  = 0;
    int         extra_max  = 0;
    logic       line;
    logic       model_busy;

    uart_sample_framer #(.DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .fifo_level(fifo_level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // UART TX model: registered ready, accepts a strobe seen while idle, shifts 10 bits.
    logic       v_prev;
    logic [7:0] d_prev;
    logic [9:0] shreg;
    int         tick, stale_left, extra_left;
    initial begin
        v_prev = 1'b0; d_prev = '0; shreg = '1; tick = 0; stale_left = 0; extra_left = 0;
        tx_ready = 1'b1; line = 1'b1; model_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (model_busy) begin
                tick++;
                if (stale_left > 0) begin
                    stale_left--;
                    if (stale_left == 0) tx_ready = 1'b0;
                end
                if (tick < 10*CPB) line = shreg[tick/CPB];
                else begin
                    line = 1'b1;
                    if (extra_left > 0) extra_left--;
                    else begin model_busy = 1'b0; tx_ready = 1'b1; end
                end
            end else if (v_prev) begin
                cap_q.push_back(d_prev);
                shreg = {1'b1, d_prev, 1'b0};
                model_busy = 1'b1;
                tick = 0;
                line = shreg[0];
                stale_left = stale_cfg;
                extra_left = (extra_max > 0) ? int'($urandom_range(0, extra_max)) : 0;
                if (stale_left == 0) tx_ready = 1'b0;
            end
            if (v_prev) strobe_cnt++;
            v_prev = tx_valid;
            d_prev = tx_data;
        end
    end

    // Serial line decoder, samples mid-bit on the falling clock edge.
    logic [7:0] rx_b;
    initial begin
        rx_b = '0;
        forever begin
            @(negedge clk);
            if (line === 1'b0) begin
                repeat (CPB + 1) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    rx_b[i] = line;
                    repeat (CPB) @(negedge clk);
                end
                checks++;
                if (line !== 1'b1) begin
                    errors++;
                    $display("FAIL rx_stop_bit: line=%b required 1", line);
                end
                rx_q.push_back(rx_b);
            end
        end
    end

    function automatic void push_frame(input logic [15:0] s);
        exp_q.push_back(8'hA5);
        exp_q.push_back(s[15:8]);
        exp_q.push_back(s[7:0]);
        exp_q.push_back(s[15:8] ^ s[7:0]);
    endfunction

    task automatic clear_streams();
        exp_q.delete(); cap_q.delete(); rx_q.delete(); strobe_cnt = 0;
    endtask

    task automatic write_sample(input logic [15:0] s);
        sample_in = s; sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input string tag);
        int c = 0;
        while ((cap_q.size() < n || rx_q.size() < n || model_busy) && c < n*60 + 300) begin
            @(posedge clk); #1; c++;
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (cap_q.size() < n || rx_q.size() < n) begin
            errors++;
            $display("FAIL %s_timeout: captured %0d decoded %0d required %0d", tag, cap_q.size(), rx_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sample_valid = 1'b0; sample_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks += 5;
        if (sample_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", sample_ready); end
        if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h required 00", tx_data); end
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b required 0", tx_valid); end
        if (fifo_level !== '0) begin errors++; $display("FAIL reset_level: got %0d required 0", fifo_level); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", overflow); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        clear_streams();
        push_frame(16'h1234);
        write_sample(16'h1234);
        checks += 2;
        if (fifo_level !== 5'd1) begin errors++; $display("FAIL single_level_after_write: got %0d required 1", fifo_level); end
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_early_strobe0: got %b required 0", tx_valid); end
        @(posedge clk); #1;
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_early_strobe1: got %b required 0", tx_valid); end
        @(posedge clk); #1;
        checks += 2;
        if (tx_valid !== 1'b1) begin errors++; $display("FAIL single_latency: tx_valid=%b required 1", tx_valid); end
        if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_first_byte: got %h required a5", tx_data); end
        wait_bytes(4, "single");
        for (int i = 0; i < exp_q.size(); i++) begin
            checks += 2;
            if (cap_q.size() <= i || cap_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL single_byte%0d: got %h required %h", i, (cap_q.size() > i) ? cap_q[i] : 8'hxx, exp_q[i]);
            end
            if (rx_q.size() <= i || rx_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL single_serial%0d: got %h required %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, exp_q[i]);
            end
        end
        checks += 3;
        if (strobe_cnt != 4) begin errors++; $display("FAIL single_strobes: got %0d required 4", strobe_cnt); end
        if (tx_data !== 8'h26) begin errors++; $display("FAIL single_data_hold: got %h required 26", tx_data); end
        if (fifo_level !== '0) begin errors++; $display("FAIL single_level_end: got %0d required 0", fifo_level); end
    endtask

    task automatic test_fill();
        logic [15:0] s;
        clear_streams();
        s = 16'($urandom);
        push_frame(s);
        write_sample(s);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            s = 16'($urandom);
            push_frame(s);
            sample_in = s; sample_valid = 1'b1;
            @(posedge clk); #1;
        end
        sample_valid = 1'b0;
        checks += 3;
        if (fifo_level !== 5'(DEPTH)) begin errors++; $display("FAIL fill_level: got %0d required %0d", fifo_level, DEPTH); end
        if (sample_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b required 0", sample_ready); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow_early: got %b required 0", overflow); end
        write_sample(16'($urandom));
        checks += 2;
        if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow: got %b required 1", overflow); end
        if (fifo_level !== 5'(DEPTH)) begin errors++; $display("FAIL fill_level_drop: got %0d required %0d", fifo_level, DEPTH); end
        wait_bytes(4*(DEPTH+1), "fill");
        for (int i = 0; i < exp_q.size(); i++) begin
            checks += 2;
            if (cap_q.size() <= i || cap_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL fill_byte%0d: got %h required %h", i, (cap_q.size() > i) ? cap_q[i] : 8'hxx, exp_q[i]);
            end
            if (rx_q.size() <= i || rx_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL fill_serial%0d: got %h required %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, exp_q[i]);
            end
        end
        checks += 2;
        if (strobe_cnt != 4*(DEPTH+1)) begin errors++; $display("FAIL fill_strobes: got %0d required %0d", strobe_cnt, 4*(DEPTH+1)); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow_sticky: got %b required 1", overflow); end
    endtask

    task automatic test_stale();
        logic [15:0] s;
        clear_streams();
        stale_cfg = 3;
        s = 16'($urandom);
        push_frame(s);
        write_sample(s);
        wait_bytes(4, "stale");
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (cap_q.size() <= i || cap_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL stale_byte%0d: got %h required %h", i, (cap_q.size() > i) ? cap_q[i] : 8'hxx, exp_q[i]);
            end
        end
        checks++;
        if (strobe_cnt != 4) begin errors++; $display("FAIL stale_strobes: got %0d required 4", strobe_cnt); end
        stale_cfg = 0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] s;
        clear_streams();
        s = 16'($urandom);
        push_frame(s);
        write_sample(s);
        repeat (2) @(posedge clk);
        #1;
        push_frame(16'hFFFF);
        push_frame(16'h0000);
        write_sample(16'hFFFF);
        write_sample(16'h0000);
        checks++;
        if (fifo_level !== 5'd2) begin errors++; $display("FAIL b2b_level: got %0d required 2", fifo_level); end
        wait_bytes(12, "b2b");
        for (int i = 0; i < exp_q.size(); i++) begin
            checks += 2;
            if (cap_q.size() <= i || cap_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL b2b_byte%0d: got %h required %h", i, (cap_q.size() > i) ? cap_q[i] : 8'hxx, exp_q[i]);
            end
            if (rx_q.size() <= i || rx_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL b2b_serial%0d: got %h required %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, exp_q[i]);
            end
        end
        checks += 2;
        if (fifo_level !== '0) begin errors++; $display("FAIL b2b_level_end: got %0d required 0", fifo_level); end
        if (strobe_cnt != 12) begin errors++; $display("FAIL b2b_strobes: got %0d required 12", strobe_cnt); end
    endtask

    task automatic test_reset_mid();
        int c = 0;
        clear_streams();
        write_sample(16'hBEEF);
        repeat (2) @(posedge clk);
        #1;
        write_sample(16'h1111);
        while (cap_q.size() < 3 && c < 600) begin @(posedge clk); #1; c++; end
        checks++;
        if (cap_q.size() < 3) begin errors++; $display("FAIL rstmid_reach_byte2: captured %0d required 3", cap_q.size()); end
        rst = 1'b1;
        #1;
        checks += 5;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_tx_valid: got %b required 0", tx_valid); end
        if (fifo_level !== '0) begin errors++; $display("FAIL rstmid_level: got %0d required 0", fifo_level); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_overflow: got %b required 0", overflow); end
        if (sample_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b required 1", sample_ready); end
        if (tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_tx_data: got %h required 00", tx_data); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        c = 0;
        while (model_busy && c < 200) begin @(posedge clk); #1; c++; end
        repeat (10) @(posedge clk);
        #1;
        clear_streams();
        push_frame(16'h00A5);
        write_sample(16'h00A5);
        wait_bytes(4, "rstmid");
        for (int i = 0; i < exp_q.size(); i++) begin
            checks += 2;
            if (cap_q.size() <= i || cap_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rstmid_byte%0d: got %h required %h", i, (cap_q.size() > i) ? cap_q[i] : 8'hxx, exp_q[i]);
            end
            if (rx_q.size() <= i || rx_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rstmid_serial%0d: got %h required %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, exp_q[i]);
            end
        end
        checks++;
        if (strobe_cnt != 4) begin errors++; $display("FAIL rstmid_strobes: got %0d required 4", strobe_cnt); end
    endtask

    task automatic test_random();
        logic [15:0] s;
        clear_streams();
        extra_max = 3;
        for (int n = 0; n < 12; n++) begin
            s = 16'($urandom);
            push_frame(s);
            write_sample(s);
            repeat ($urandom_range(0, 60)) @(posedge clk);
            #1;
        end
        wait_bytes(48, "random");
        for (int i = 0; i < exp_q.size(); i++) begin
            checks += 2;
            if (cap_q.size() <= i || cap_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL random_byte%0d: got %h required %h", i, (cap_q.size() > i) ? cap_q[i] : 8'hxx, exp_q[i]);
            end
            if (rx_q.size() <= i || rx_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL random_serial%0d: got %h required %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, exp_q[i]);
            end
        end
        checks += 3;
        if (strobe_cnt != 48) begin errors++; $display("FAIL random_strobes: got %0d required 48", strobe_cnt); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL random_overflow: got %b required 0", overflow); end
        if (fifo_level !== '0) begin errors++; $display("FAIL random_level_end: got %0d required 0", fifo_level); end
        extra_max = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stale();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
